// File: rtl/w5300_pkg.sv
// Shared W5300 definitions: control-word fields, bus FSM states, register
// addresses used by the UDP controller, and a cycle-count helper.
package w5300_pkg;

  // caddr field positions
  localparam int CADDR_VALID_N  = 11;
  localparam int CADDR_RD       = 10;
  localparam int CADDR_ADDR_MSB = 9;

  // A few W5300 direct-mode register byte addresses
  localparam logic [9:0] REG_MR   = 10'h000;
  localparam logic [9:0] REG_IR   = 10'h002;
  localparam logic [9:0] REG_IMR  = 10'h004;
  localparam logic [9:0] REG_SHAR = 10'h008;
  localparam logic [9:0] REG_IDR  = 10'h0FE;
  localparam logic [9:0] REG_S0   = 10'h200;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_PLL_WAIT,
    ST_PWR_DONE,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } bus_state_t;

  // Clock cycles covering ns at mhz, rounded up, never below one
  function automatic int ns_to_cycles(input int ns, input int mhz);
    int c;
    c = (ns * mhz + 999) / 1000;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/w5300_parallel_bus.sv
// W5300 16-bit direct-address bus engine: hardware reset / PLL-lock wait,
// then one timed register read or write per request on caddr.
module w5300_parallel_bus
  import w5300_pkg::*;
#(
  parameter int CLK_FREQ    = 100,
  parameter int T_SETUP_NS  = 10,
  parameter int T_STROBE_NS = 70,
  parameter int T_HOLD_NS   = 10,
  parameter int RST_LOW_US  = 2,
  parameter int PLL_LOCK_US = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] caddr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        op_status,
  output logic        w_rst_n,
  output logic [9:0]  w_addr,
  output logic        w_cs_n,
  output logic        w_rd_n,
  output logic        w_wr_n,
  input  logic [15:0] w_data_i,
  output logic [15:0] w_data_o,
  output logic        w_data_oe
);

  localparam int N_SETUP  = ns_to_cycles(T_SETUP_NS, CLK_FREQ);
  localparam int N_STROBE = ns_to_cycles(T_STROBE_NS, CLK_FREQ);
  localparam int N_HOLD   = ns_to_cycles(T_HOLD_NS, CLK_FREQ);
  localparam int N_RST    = RST_LOW_US * CLK_FREQ;
  localparam int N_PLL    = PLL_LOCK_US * CLK_FREQ;

  localparam int MAX_A   = (N_RST > N_PLL) ? N_RST : N_PLL;
  localparam int MAX_B   = (N_SETUP > N_STROBE) ? N_SETUP : N_STROBE;
  localparam int MAX_C   = (MAX_B > N_HOLD) ? MAX_B : N_HOLD;
  localparam int MAX_CNT = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  // Counter reload: a phase of n cycles counts n-1 down to 0
  function automatic logic [CW-1:0] ld(input int n);
    return CW'(n - 1);
  endfunction

  bus_state_t    state;
  logic [CW-1:0] cnt;
  logic          is_rd;
  logic          cnt_zero;

  assign cnt_zero = (cnt == '0);

  // Bus FSM: every pin is a register; async reset drops all strobes at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST_LOW;
      cnt       <= ld(N_RST);
      is_rd     <= 1'b0;
      w_rst_n   <= 1'b0;
      w_cs_n    <= 1'b1;
      w_rd_n    <= 1'b1;
      w_wr_n    <= 1'b1;
      w_data_oe <= 1'b0;
      w_addr    <= '0;
      w_data_o  <= '0;
      rd_data   <= '0;
      op_status <= 1'b0;
    end else begin
      op_status <= 1'b0;
      case (state)
        ST_RST_LOW: begin
          if (cnt_zero) begin
            w_rst_n <= 1'b1;
            cnt     <= ld(N_PLL);
            state   <= ST_PLL_WAIT;
          end else cnt <= cnt - 1'b1;
        end
        ST_PLL_WAIT: begin
          if (cnt_zero) begin
            op_status <= 1'b1;
            state     <= ST_PWR_DONE;
          end else cnt <= cnt - 1'b1;
        end
        ST_PWR_DONE: state <= ST_IDLE;
        ST_IDLE: begin
          if (!caddr[CADDR_VALID_N]) begin
            is_rd  <= caddr[CADDR_RD];
            w_addr <= caddr[CADDR_ADDR_MSB:0];
            w_cs_n <= 1'b0;
            if (!caddr[CADDR_RD]) begin
              w_data_o  <= wr_data;
              w_data_oe <= 1'b1;
            end
            cnt   <= ld(N_SETUP);
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            if (is_rd) w_rd_n <= 1'b0;
            else       w_wr_n <= 1'b0;
            cnt   <= ld(N_STROBE);
            state <= ST_STROBE;
          end else cnt <= cnt - 1'b1;
        end
        ST_STROBE: begin
          if (cnt_zero) begin
            w_rd_n <= 1'b1;
            w_wr_n <= 1'b1;
            if (is_rd) rd_data <= w_data_i;
            cnt   <= ld(N_HOLD);
            state <= ST_HOLD;
          end else cnt <= cnt - 1'b1;
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            w_cs_n    <= 1'b1;
            w_data_oe <= 1'b0;
            op_status <= 1'b1;
            state     <= ST_DONE;
          end else cnt <= cnt - 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_w5300_parallel_bus.sv
// Bench for w5300_parallel_bus: power-up timing, table and random register
// accesses against a W5300 memory model, async reset, 50 MHz strobe width.
module tb_w5300_parallel_bus;
  import w5300_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] caddr = 12'h800;
  logic [11:0] caddr2 = 12'h800;
  logic [15:0] wr_data = '0;

  logic [15:0] rd_data, rd_data2, w_data_i, w_data_i2, w_data_o, w_data_o2;
  logic        op_status, op_status2, w_rst_n, w_rst_n2;
  logic [9:0]  w_addr, w_addr2;
  logic        w_cs_n, w_rd_n, w_wr_n, w_data_oe;
  logic        w_cs_n2, w_rd_n2, w_wr_n2, w_data_oe2;

  logic [15:0] pin_mem [0:1023];
  logic [15:0] ref_mem [0:1023];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // W5300 pin model: data only driven while RD_n is low
  assign w_data_i  = w_rd_n  ? 16'hDEAD : pin_mem[w_addr];
  assign w_data_i2 = w_rd_n2 ? 16'hBEEF : pin_mem[w_addr2];

  w5300_parallel_bus #(.CLK_FREQ(100), .RST_LOW_US(1), .PLL_LOCK_US(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .caddr(caddr), .wr_data(wr_data),
    .rd_data(rd_data), .op_status(op_status), .w_rst_n(w_rst_n),
    .w_addr(w_addr), .w_cs_n(w_cs_n), .w_rd_n(w_rd_n), .w_wr_n(w_wr_n),
    .w_data_i(w_data_i), .w_data_o(w_data_o), .w_data_oe(w_data_oe)
  );

  w5300_parallel_bus #(.CLK_FREQ(50), .RST_LOW_US(1), .PLL_LOCK_US(1)) u_dut50 (
    .clk(clk), .rst_n(rst_n), .caddr(caddr2), .wr_data(wr_data),
    .rd_data(rd_data2), .op_status(op_status2), .w_rst_n(w_rst_n2),
    .w_addr(w_addr2), .w_cs_n(w_cs_n2), .w_rd_n(w_rd_n2), .w_wr_n(w_wr_n2),
    .w_data_i(w_data_i2), .w_data_o(w_data_o2), .w_data_oe(w_data_oe2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reset, then time RESET_n low and PLL wait; caddr=000 must not start an access
  task automatic powerup();
    int c, bad, pulses;
    rst_n = 1'b0; caddr = 12'h000; caddr2 = 12'h800; wr_data = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("reset w_rst_n", w_rst_n, 0);
    check("reset strobes cs/rd/wr/oe", {w_cs_n, w_rd_n, w_wr_n, w_data_oe}, 4'b1110);
    check("reset op_status", op_status, 0);
    check("reset rd_data", rd_data, 0);
    check("reset w_addr/w_data_o", {w_addr, w_data_o}, 0);
    rst_n = 1'b1;
    c = 0; bad = 0;
    while (!w_rst_n && c < 1000) begin
      @(posedge clk); #1; c++;
      if ({w_cs_n, w_rd_n, w_wr_n} != 3'b111) bad++;
    end
    check("rst low cycles", c, 100);
    c = 0;
    while (!op_status && c < 1000) begin
      @(posedge clk); #1; c++;
      if ({w_cs_n, w_rd_n, w_wr_n} != 3'b111) bad++;
    end
    check("pll wait cycles", c, 100);
    caddr = 12'h800;
    pulses = op_status ? 1 : 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (op_status) pulses++;
      if ({w_cs_n, w_rd_n, w_wr_n} != 3'b111) bad++;
    end
    check("pwr_done pulses", pulses, 1);
    check("strobes during powerup", bad, 0);
  endtask

  // One access, measured cycle by cycle at negedge
  task automatic do_op(input bit rd, input logic [9:0] a, input logic [15:0] d,
                       input bit mutate, output logic [15:0] got_rd);
    int cyc, rdl, wrl, csl, bad_addr, bad_oe, bad_data, bad_inv;
    logic prev_wr, cap;
    logic [9:0] cap_a;
    logic [15:0] cap_d, rd_before;
    rd_before = rd_data;
    cyc = 0; rdl = 0; wrl = 0; csl = 0;
    bad_addr = 0; bad_oe = 0; bad_data = 0; bad_inv = 0;
    prev_wr = 1'b1; cap = 1'b0; cap_a = '0; cap_d = '0;
    @(negedge clk);
    caddr = {1'b0, rd, a}; wr_data = d;
    while (cyc < 40) begin
      @(negedge clk); cyc++;
      if (cyc == 3 && mutate) begin caddr = {1'b0, ~rd, ~a}; wr_data = ~d; end
      if (!w_cs_n) begin csl++; if (w_addr !== a) bad_addr++; end
      if (!w_rd_n) rdl++;
      if (!w_wr_n) wrl++;
      if (w_data_oe !== (!rd && !w_cs_n)) bad_oe++;
      if (w_data_oe && w_data_o !== d) bad_data++;
      if ((!w_rd_n && !w_wr_n) || (w_data_oe && !w_rd_n)) bad_inv++;
      if (!prev_wr && w_wr_n) begin cap = 1'b1; cap_a = w_addr; cap_d = w_data_o; end
      prev_wr = w_wr_n;
      if (op_status) break;
    end
    caddr = 12'h800;
    check("latency", cyc + 1, 11);
    check("strobe width", rd ? rdl : wrl, 7);
    check("other strobe idle", rd ? wrl : rdl, 0);
    check("cs low cycles", csl, 9);
    check("addr stable", bad_addr, 0);
    check("oe tracks cs", bad_oe, 0);
    check("w_data_o stable", bad_data, 0);
    check("strobe exclusivity", bad_inv, 0);
    check("cs/oe released at done", {w_cs_n, w_data_oe}, 2'b10);
    if (!rd) begin
      check("write seen", cap, 1);
      check("write addr", cap_a, a);
      check("write data", cap_d, d);
      if (cap) pin_mem[cap_a] = cap_d;
      check("rd_data kept on write", rd_data, rd_before);
    end
    got_rd = rd_data;
  endtask

  typedef struct {
    bit          rd;
    logic [9:0]  addr;
    logic [15:0] wdata;
    bit          mutate;
    logic [15:0] exp_rd;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [15:0] got, exp_last;
    bit rd;
    logic [9:0] a;
    logic [15:0] d;
    int cyc, rdl, csl;

    for (int i = 0; i < 1024; i++) pin_mem[i] = 16'($urandom);
    pin_mem[10'h0FE] = 16'h5300;
    pin_mem[10'h3FF] = 16'h0BAD;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pin_mem[i];

    tbl[0] = '{1'b1, 10'h0FE, 16'h0000, 1'b0, 16'h5300};
    tbl[1] = '{1'b0, 10'h000, 16'h0002, 1'b0, 16'h5300};
    tbl[2] = '{1'b1, 10'h000, 16'h0000, 1'b1, 16'h0002};
    tbl[3] = '{1'b0, 10'h202, 16'hA5C3, 1'b1, 16'h0002};
    tbl[4] = '{1'b1, 10'h202, 16'h0000, 1'b0, 16'hA5C3};
    tbl[5] = '{1'b1, 10'h3FF, 16'h0000, 1'b0, 16'h0BAD};

    powerup();

    // Directed table: reads, writes, back-to-back with mid-access caddr changes
    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].mutate, got);
      check($sformatf("tbl[%0d] rd_data", i), got, tbl[i].exp_rd);
      if (!tbl[i].rd) ref_mem[tbl[i].addr] = tbl[i].wdata;
    end
    exp_last = 16'h0BAD;

    // 50 MHz instance: setup 1, strobe 4, hold 1
    @(negedge clk);
    caddr2 = {1'b0, 1'b1, 10'h0FE};
    cyc = 0; rdl = 0; csl = 0;
    while (cyc < 40) begin
      @(negedge clk); cyc++;
      if (!w_rd_n2) rdl++;
      if (!w_cs_n2) csl++;
      if (op_status2) break;
    end
    caddr2 = 12'h800;
    check("50MHz strobe", rdl, 4);
    check("50MHz cs low", csl, 6);
    check("50MHz latency", cyc + 1, 8);
    check("50MHz rd_data", rd_data2, 16'h5300);

    // Random accesses against the reference memory
    for (int i = 0; i < 30; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 10'($urandom_range(0, 15) * 64 + 2);
      d  = 16'($urandom);
      do_op(rd, a, d, 1'($urandom_range(0, 1)), got);
      if (rd) exp_last = ref_mem[a];
      else    ref_mem[a] = d;
      check("random rd_data", got, exp_last);
    end

    // Reset in the middle of a write strobe
    @(negedge clk);
    caddr = {1'b0, 1'b0, 10'h155}; wr_data = 16'h7777;
    cyc = 0;
    while (w_wr_n && cyc < 20) begin @(negedge clk); cyc++; end
    check("write strobe reached", w_wr_n, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async release wr/cs/oe", {w_wr_n, w_cs_n, w_data_oe}, 3'b110);
    check("async w_rst_n", w_rst_n, 0);
    powerup();
    do_op(1'b1, 10'h0FE, 16'h0, 1'b0, got);
    check("post-reset read", got, 16'h5300);
    do_op(1'b1, 10'h155, 16'h0, 1'b0, got);
    check("aborted write not committed", got, ref_mem[10'h155]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
